// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage.
// The ex_* operands come from ID/EX and the *_o results go to EX/MEM.
// While stall_req=1, the ID/EX register holds its contents and EX/MEM loads a bubble.
interface ex_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic [1:0]            ex_aluop;
    logic [3:0]            ex_alufun;
    logic [XLEN-1:0]       ex_reg1;
    logic [XLEN-1:0]       ex_reg2;
    logic [REG_ADDR_W-1:0] ex_wd;
    logic                  ex_wreg;
    logic [REG_ADDR_W-1:0] wd_o;
    logic                  wreg_o;
    logic [XLEN-1:0]       wdata_o;
    logic                  stall_req;

    modport master (
        output ex_aluop, ex_alufun, ex_reg1, ex_reg2, ex_wd, ex_wreg,
        input  wd_o, wreg_o, wdata_o, stall_req
    );

    modport slave (
        input  ex_aluop, ex_alufun, ex_reg1, ex_reg2, ex_wd, ex_wreg,
        output wd_o, wreg_o, wdata_o, stall_req
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: combinational RV32I ALU and RV32M multiply, plus an iterative
// restoring divider (one quotient bit per cycle) that stalls the pipeline while it runs.
module ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    ex_stage_if.slave    bus,
    output logic [1:0]   dbg_state_o
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_e;

    div_state_e      state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic            neg_quo_q, neg_rem_q, is_rem_q;

    logic [XLEN-1:0] a, b;
    logic [2:0]      f3;
    logic            fa;
    assign a  = bus.ex_reg1;
    assign b  = bus.ex_reg2;
    assign f3 = bus.ex_alufun[2:0];
    assign fa = bus.ex_alufun[3];

    logic [XLEN-1:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (f3)
            3'b000:  alu_res = fa ? (a - b) : (a + b);
            3'b001:  alu_res = a << b[4:0];
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            3'b100:  alu_res = a ^ b;
            3'b101:  alu_res = fa ? XLEN'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  alu_res = a | b;
            default: alu_res = a & b;
        endcase
    end

    // Operands are sign/zero extended to full product width so one multiplier covers all four ops.
    logic              mul_a_sgn, mul_b_sgn;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0]   mul_res;
    assign mul_a_sgn = (f3[1:0] != 2'b11) & a[XLEN-1];
    assign mul_b_sgn = ~f3[1] & b[XLEN-1];
    assign mul_a     = {{XLEN{mul_a_sgn}}, a};
    assign mul_b     = {{XLEN{mul_b_sgn}}, b};
    assign prod      = mul_a * mul_b;
    assign mul_res   = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    logic            is_div_op, div_signed, div_is_rem, div_by_zero, div_ovf, launch;
    logic [XLEN-1:0] a_abs, b_abs, special_res;
    assign is_div_op   = (bus.ex_aluop == 2'b10) & f3[2];
    assign div_signed  = ~f3[0];
    assign div_is_rem  = f3[1];
    assign div_by_zero = (b == '0);
    assign div_ovf     = div_signed & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    assign launch      = is_div_op & ~div_by_zero & ~div_ovf;
    assign a_abs       = (div_signed & a[XLEN-1]) ? -a : a;
    assign b_abs       = (div_signed & b[XLEN-1]) ? -b : b;
    // Overflow quotient is the dividend itself (0x80000000); overflow remainder is zero.
    assign special_res = div_by_zero ? (div_is_rem ? a : '1) : (div_is_rem ? '0 : a);

    // One restoring step: quo_q holds the dividend bits still to be shifted in.
    logic [XLEN:0]   rem_shift, diff;
    logic [XLEN-1:0] quo_d, rem_d, div_res;
    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};
    assign rem_d     = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_d     = {quo_q[XLEN-2:0], ~diff[XLEN]};
    assign div_res   = is_rem_q ? (neg_rem_q ? -rem_q : rem_q)
                                : (neg_quo_q ? -quo_q : quo_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        quo_q     <= a_abs;
                        rem_q     <= '0;
                        dvs_q     <= b_abs;
                        neg_quo_q <= div_signed & (a[XLEN-1] ^ b[XLEN-1]);
                        neg_rem_q <= div_signed & a[XLEN-1];
                        is_rem_q  <= div_is_rem;
                        cnt_q     <= '0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.stall_req = 1'b0;
        bus.wreg_o    = 1'b0;
        bus.wdata_o   = '0;
        bus.wd_o      = bus.ex_wd;
        dbg_state_o   = state_q;
        if (!rst) begin
            bus.wd_o    = '0;
            dbg_state_o = 2'd0;
        end else if (!flush) begin
            case (state_q)
                BUSY: bus.stall_req = 1'b1;
                DONE: begin
                    bus.wreg_o  = bus.ex_wreg;
                    bus.wdata_o = div_res;
                end
                default: begin
                    case (bus.ex_aluop)
                        2'b01: begin
                            bus.wreg_o  = bus.ex_wreg;
                            bus.wdata_o = alu_res;
                        end
                        2'b10: begin
                            if (launch) begin
                                bus.stall_req = 1'b1;
                            end else begin
                                bus.wreg_o  = bus.ex_wreg;
                                bus.wdata_o = is_div_op ? special_res : mul_res;
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end
endmodule
